// File: rtl/spi_sensor_seq.sv
// Sensor command sequencer: power-up wait, one config write, then a low/high
// byte read pair on every sensor data-ready edge, assembled into a 16-bit sample.
module spi_sensor_seq #(
  parameter logic [15:0] INIT_WAIT = 16'd32,
  parameter logic [15:0] CFG_CMD   = 16'h0D02,
  parameter logic [15:0] RD_LO_CMD = 16'hA200,
  parameter logic [15:0] RD_HI_CMD = 16'hA300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_wt_data,
  output logic [15:0] sample,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CFG      = 3'd1,
    CFG_W    = 3'd2,
    IDLE     = 3'd3,
    LO_W     = 3'd4,
    HI_W     = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  blank, blank_n;
  logic        pending, pending_n;
  logic [7:0]  lo_byte, lo_byte_n;
  logic        spi_wrt_n;
  logic [15:0] wt_data_n;
  logic [15:0] sample_n;
  logic        vld_n;
  logic        init_done_n;

  logic        int_s1, int_s2, int_d;
  logic        int_rise;
  logic        complete;
  logic        unused_rd_bits;

  // The sensor returns bytes; the upper half of the received word carries nothing.
  assign unused_rd_bits = ^spi_rd_data[15:8];

  assign int_rise = int_s2 & ~int_d;

  // blank is loaded with 2 on every issue, so the stale done level left over
  // from the previous transaction is ignored in the wrt cycle and the one after.
  assign complete = spi_done && (blank == 2'd0);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    blank_n     = (blank != 2'd0) ? blank - 2'd1 : 2'd0;
    pending_n   = pending | (int_rise && (state != IDLE));
    lo_byte_n   = lo_byte;
    spi_wrt_n   = 1'b0;
    wt_data_n   = spi_wt_data;
    sample_n    = sample;
    vld_n       = 1'b0;
    init_done_n = init_done;

    case (state)
      PWR_WAIT: begin
        cnt_n = cnt + 16'd1;
        if (cnt == INIT_WAIT - 16'd1) begin
          state_n = CFG;
        end
      end

      CFG: begin
        spi_wrt_n = 1'b1;
        wt_data_n = CFG_CMD;
        blank_n   = 2'd2;
        state_n   = CFG_W;
      end

      CFG_W: begin
        if (complete) begin
          init_done_n = 1'b1;
          state_n     = IDLE;
        end
      end

      IDLE: begin
        if (int_rise || pending) begin
          pending_n = 1'b0;
          spi_wrt_n = 1'b1;
          wt_data_n = RD_LO_CMD;
          blank_n   = 2'd2;
          state_n   = LO_W;
        end
      end

      LO_W: begin
        if (complete) begin
          lo_byte_n = spi_rd_data[7:0];
          spi_wrt_n = 1'b1;
          wt_data_n = RD_HI_CMD;
          blank_n   = 2'd2;
          state_n   = HI_W;
        end
      end

      HI_W: begin
        if (complete) begin
          sample_n = {spi_rd_data[7:0], lo_byte};
          vld_n    = 1'b1;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PWR_WAIT;
      cnt         <= 16'd0;
      blank       <= 2'd0;
      pending     <= 1'b0;
      int_s1      <= 1'b0;
      int_s2      <= 1'b0;
      int_d       <= 1'b0;
      spi_wrt     <= 1'b0;
      spi_wt_data <= 16'h0000;
      sample      <= 16'h0000;
      vld         <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      blank       <= blank_n;
      pending     <= pending_n;
      int_s1      <= INT;
      int_s2      <= int_s1;
      int_d       <= int_s2;
      spi_wrt     <= spi_wrt_n;
      spi_wt_data <= wt_data_n;
      sample      <= sample_n;
      vld         <= vld_n;
      init_done   <= init_done_n;
    end
  end

  // Low-byte holding register is always written before it is read.
  always_ff @(posedge clk) begin
    lo_byte <= lo_byte_n;
  end

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Directed bench for spi_sensor_seq with a behavioural SPI monarch responder.
module tb_spi_sensor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        spi_done = 1'b1;
  logic [15:0] spi_rd_data = 16'hFFFF;
  logic        spi_wrt;
  logic [15:0] spi_wt_data;
  logic [15:0] sample;
  logic        vld;
  logic        init_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rel_cyc = 0;

  // responder configuration
  int          lat = 40;
  bit          slow_clr = 1'b0;
  logic [15:0] lo_resp = 16'h0034;
  logic [15:0] hi_resp = 16'h0012;
  logic        busy = 1'b0;
  logic        clr_pend = 1'b0;
  int          cd = 0;
  logic [15:0] cmd = 16'h0000;

  // event logs
  int          wrt_cyc[$];
  logic [15:0] wrt_dat[$];
  int          vld_cyc[$];
  logic [15:0] vld_smp[$];
  int          init_rise_cyc = -1;
  int          done_rise_cyc = -1;
  logic        init_prev = 1'b0;
  logic        done_prev = 1'b1;

  spi_sensor_seq dut (
    .clk         (clk),
    .rst         (rst),
    .INT         (INT),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .spi_wrt     (spi_wrt),
    .spi_wt_data (spi_wt_data),
    .sample      (sample),
    .vld         (vld),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI monarch: done drops on wrt (or one cycle later in slow_clr mode),
  // rises lat cycles later with the response picked by the command word.
  always @(posedge clk) begin
    if (clr_pend) begin
      spi_done <= 1'b0;
      clr_pend <= 1'b0;
    end
    if (spi_wrt) begin
      if (slow_clr) clr_pend <= 1'b1;
      else spi_done <= 1'b0;
      busy <= 1'b1;
      cd   <= lat;
      cmd  <= spi_wt_data;
    end else if (busy) begin
      if (cd == 1) begin
        spi_done    <= 1'b1;
        busy        <= 1'b0;
        spi_rd_data <= (cmd == 16'hA200) ? lo_resp :
                       (cmd == 16'hA300) ? hi_resp : 16'hFFFF;
      end
      cd <= cd - 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (spi_wrt) begin
      wrt_cyc.push_back(cyc);
      wrt_dat.push_back(spi_wt_data);
    end
    if (vld) begin
      vld_cyc.push_back(cyc);
      vld_smp.push_back(sample);
    end
    if (init_done && !init_prev) init_rise_cyc = cyc;
    if (spi_done && !done_prev) done_rise_cyc = cyc;
    init_prev = init_done;
    done_prev = spi_done;
  end

  task automatic clear_logs();
    wrt_cyc.delete();
    wrt_dat.delete();
    vld_cyc.delete();
    vld_smp.delete();
  endtask

  task automatic wait_wrts(input int n, input int budget, output bit ok);
    int k = 0;
    while (wrt_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (wrt_cyc.size() >= n);
  endtask

  task automatic wait_vlds(input int n, input int budget, output bit ok);
    int k = 0;
    while (vld_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (vld_cyc.size() >= n);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    init_rise_cyc = -1;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (spi_wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b want 0", spi_wrt); end
    checks++; if (spi_wt_data !== 16'h0000) begin errors++; $display("FAIL reset_wt_data: got %h want 0000", spi_wt_data); end
    checks++; if (sample !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h want 0000", sample); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", vld); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
  endtask

  task automatic test_power_up();
    bit ok;
    wait_wrts(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pwr_wrt_timeout: got none want 1 wrt"); return; end
    checks++; if (wrt_cyc[0] - rel_cyc !== 33) begin errors++; $display("FAIL pwr_wrt_delay: got %0d want 33", wrt_cyc[0] - rel_cyc); end
    checks++; if (wrt_dat[0] !== 16'h0D02) begin errors++; $display("FAIL pwr_cfg_cmd: got %h want 0d02", wrt_dat[0]); end
    @(negedge clk);
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL pwr_blank1: init_done got %b want 0", init_done); end
    @(negedge clk);
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL pwr_blank2: init_done got %b want 0", init_done); end
    repeat (60) @(negedge clk);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL pwr_init_done: got %b want 1", init_done); end
    checks++; if (init_rise_cyc - done_rise_cyc !== 1) begin errors++; $display("FAIL pwr_init_timing: got %0d want 1", init_rise_cyc - done_rise_cyc); end
    checks++; if (vld_cyc.size() !== 0) begin errors++; $display("FAIL pwr_no_vld: got %0d want 0", vld_cyc.size()); end
    checks++; if (wrt_cyc.size() !== 1) begin errors++; $display("FAIL pwr_wrt_count: got %0d want 1", wrt_cyc.size()); end
  endtask

  task automatic test_single_read();
    bit ok;
    int n0;
    lat = 5; slow_clr = 1'b0; lo_resp = 16'h0034; hi_resp = 16'h0012;
    clear_logs();
    @(negedge clk);
    INT = 1'b1;
    n0 = cyc;
    wait_vlds(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_vld_timeout: got none want 1 vld"); INT = 1'b0; return; end
    repeat (5) @(negedge clk);
    INT = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (wrt_cyc.size() !== 2) begin errors++; $display("FAIL single_wrt_count: got %0d want 2", wrt_cyc.size()); return; end
    checks++; if (wrt_cyc[0] - n0 < 3 || wrt_cyc[0] - n0 > 4) begin errors++; $display("FAIL single_int_latency: got %0d want 3..4", wrt_cyc[0] - n0); end
    checks++; if (wrt_dat[0] !== 16'hA200) begin errors++; $display("FAIL single_lo_cmd: got %h want a200", wrt_dat[0]); end
    checks++; if (wrt_dat[1] !== 16'hA300) begin errors++; $display("FAIL single_hi_cmd: got %h want a300", wrt_dat[1]); end
    checks++; if (wrt_cyc[1] - wrt_cyc[0] !== 7) begin errors++; $display("FAIL single_lo_turnaround: got %0d want 7", wrt_cyc[1] - wrt_cyc[0]); end
    checks++; if (vld_smp[0] !== 16'h1234) begin errors++; $display("FAIL single_sample: got %h want 1234", vld_smp[0]); end
    checks++; if (vld_cyc.size() !== 1) begin errors++; $display("FAIL single_vld_width: got %0d want 1", vld_cyc.size()); end
    checks++; if (sample !== 16'h1234 || vld !== 1'b0) begin errors++; $display("FAIL single_hold: got %h/%b want 1234/0", sample, vld); end
  endtask

  task automatic test_stale_done();
    bit ok;
    lat = 6; slow_clr = 1'b1; lo_resp = 16'hAB56; hi_resp = 16'hCD78;
    clear_logs();
    @(negedge clk); INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    wait_vlds(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stale_vld_timeout: got none want 1 vld"); return; end
    checks++; if (wrt_cyc.size() !== 2) begin errors++; $display("FAIL stale_wrt_count: got %0d want 2", wrt_cyc.size()); return; end
    checks++; if (wrt_cyc[1] - wrt_cyc[0] !== 8) begin errors++; $display("FAIL stale_lo_wait: got %0d want 8", wrt_cyc[1] - wrt_cyc[0]); end
    checks++; if (vld_cyc[0] - wrt_cyc[1] !== 8) begin errors++; $display("FAIL stale_hi_wait: got %0d want 8", vld_cyc[0] - wrt_cyc[1]); end
    checks++; if (vld_smp[0] !== 16'h7856) begin errors++; $display("FAIL stale_sample: got %h want 7856", vld_smp[0]); end
    slow_clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    lat = 10; lo_resp = 16'h0011; hi_resp = 16'h0022;
    clear_logs();
    @(negedge clk); INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    wait_wrts(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got none want 1 wrt"); return; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); INT = 1'b1;
      @(negedge clk);
      @(negedge clk); INT = 1'b0;
      @(negedge clk);
    end
    wait_vlds(2, 200, ok);
    repeat (60) @(negedge clk);
    checks++; if (vld_cyc.size() !== 2) begin errors++; $display("FAIL b2b_vld_count: got %0d want 2", vld_cyc.size()); return; end
    checks++; if (wrt_cyc.size() !== 4) begin errors++; $display("FAIL b2b_wrt_count: got %0d want 4", wrt_cyc.size()); return; end
    checks++; if (wrt_cyc[2] - vld_cyc[0] !== 1) begin errors++; $display("FAIL b2b_restart: got %0d want 1", wrt_cyc[2] - vld_cyc[0]); end
    checks++; if (wrt_dat[2] !== 16'hA200) begin errors++; $display("FAIL b2b_lo_cmd: got %h want a200", wrt_dat[2]); end
    checks++; if (vld_smp[1] !== 16'h2211) begin errors++; $display("FAIL b2b_sample: got %h want 2211", vld_smp[1]); end
  endtask

  task automatic test_early_int();
    bit ok;
    lat = 8; lo_resp = 16'h00EF; hi_resp = 16'h00BE;
    do_reset(2);
    repeat (10) @(negedge clk);
    INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    wait_vlds(1, 300, ok);
    repeat (40) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL early_vld_timeout: got none want 1 vld"); return; end
    checks++; if (wrt_cyc.size() !== 3) begin errors++; $display("FAIL early_wrt_count: got %0d want 3", wrt_cyc.size()); return; end
    checks++; if (wrt_dat[0] !== 16'h0D02) begin errors++; $display("FAIL early_cfg_first: got %h want 0d02", wrt_dat[0]); end
    checks++; if (wrt_cyc[1] - init_rise_cyc !== 1) begin errors++; $display("FAIL early_read_start: got %0d want 1", wrt_cyc[1] - init_rise_cyc); end
    checks++; if (sample !== 16'hBEEF) begin errors++; $display("FAIL early_sample: got %h want beef", sample); end
    checks++; if (vld_cyc.size() !== 1) begin errors++; $display("FAIL early_vld_count: got %0d want 1", vld_cyc.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    lat = 10;
    clear_logs();
    @(negedge clk); INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    wait_wrts(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_lo_timeout: got none want 1 wrt"); return; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    clear_logs();
    checks++; if (spi_wrt !== 1'b0 || vld !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got wrt=%b vld=%b init=%b want 0/0/0", spi_wrt, vld, init_done); end
    checks++; if (spi_wt_data !== 16'h0000) begin errors++; $display("FAIL midrst_wt_data: got %h want 0000", spi_wt_data); end
    checks++; if (sample !== 16'h0000) begin errors++; $display("FAIL midrst_sample: got %h want 0000", sample); end
    wait_wrts(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_cfg_timeout: got none want 1 wrt"); return; end
    checks++; if (wrt_cyc[0] - rel_cyc !== 33) begin errors++; $display("FAIL midrst_cfg_delay: got %0d want 33", wrt_cyc[0] - rel_cyc); end
    checks++; if (wrt_dat[0] !== 16'h0D02) begin errors++; $display("FAIL midrst_cfg_cmd: got %h want 0d02", wrt_dat[0]); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_single_read();
    test_stale_done();
    test_back_to_back();
    test_early_int();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
